// File: rtl/snn_aer_tx_if.sv
// rtl/snn_aer_tx_if.sv - address-event stream between the AER transmitter and its consumer
interface snn_aer_tx_if #(
  parameter int ADDR_W = 3,
  parameter int TS_W   = 8
);
  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] ev_addr;
  logic [TS_W-1:0]   ev_ts;
  logic              ev_last;

  modport master (output ev_valid, ev_addr, ev_ts, ev_last, input ev_ready);
  modport slave  (input ev_valid, ev_addr, ev_ts, ev_last, output ev_ready);
endinterface

// File: rtl/snn_aer_tx.sv
// rtl/snn_aer_tx.sv - AER transmitter: timestep-tagged spike frame FIFO and per-neuron event serialiser
module snn_aer_tx #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = 3,
  parameter int TS_W      = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_strobe,
  snn_aer_tx_if.master         ev,
  input  logic                 clear,
  output logic                 overflow,
  output logic [7:0]           drop_cnt,
  output logic                 busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [N_NEURONS-1:0] mask_mem [DEPTH];
  logic [TS_W-1:0]      ts_mem   [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count, count_nxt;
  logic [TS_W-1:0]      ts;
  logic [N_NEURONS-1:0] sent, remaining, addr_onehot;
  logic [ADDR_W-1:0]    head_addr;
  logic                 push_req, push_ok, drop, xfer, pop, head_last, valid;

  // Unsent part of the head frame; its lowest bit is the event on offer.
  assign remaining = mask_mem[rd_ptr] & ~sent;

  always_comb begin
    head_addr = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (remaining[i]) head_addr = ADDR_W'(i);
    end
  end

  assign head_last   = (remaining != '0) &&
                       ((remaining & (remaining - N_NEURONS'(1))) == '0);
  assign addr_onehot = N_NEURONS'(1) << head_addr;

  assign valid    = (state == SEND);
  assign xfer     = valid & ev.ev_ready;
  assign pop      = xfer & head_last;
  assign push_req = spike_strobe & (spike_in != '0);
  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign push_ok  = push_req & ((count < FULL) | pop);
  assign drop     = push_req & ~push_ok;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push_ok) state_nxt = SEND;
      SEND:    if (pop && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mask_mem[wr_ptr] <= spike_in;
      ts_mem[wr_ptr]   <= ts;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      sent     <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      count <= count_nxt;
      if (push_ok)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)          rd_ptr <= rd_ptr + PTR_W'(1);
      if (spike_strobe) ts     <= ts + TS_W'(1);
      if (pop)       sent <= '0;
      else if (xfer) sent <= sent | addr_onehot;
      // A drop coinciding with clear is recorded as the first drop after it.
      if (clear) begin
        overflow <= drop;
        drop_cnt <= {7'd0, drop};
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign ev.ev_valid = valid;
  assign ev.ev_addr  = valid ? head_addr : '0;
  assign ev.ev_ts    = valid ? ts_mem[rd_ptr] : '0;
  assign ev.ev_last  = valid & head_last;
  assign busy        = (count != '0);
endmodule

// File: tb/tb_snn_aer_tx.sv
// tb/tb_snn_aer_tx.sv - bench for snn_aer_tx: fixed vectors, corner sequences, random traffic vs event-queue model
module tb_snn_aer_tx;
  localparam int N = 8, AW = 3, TW = 8, DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] spike_in = '0;
  logic         spike_strobe = 1'b0;
  logic         clear = 1'b0;
  logic         overflow;
  logic [7:0]   drop_cnt;
  logic         busy;

  snn_aer_tx_if #(.ADDR_W(AW), .TS_W(TW)) ev_if ();

  snn_aer_tx #(.N_NEURONS(N), .ADDR_W(AW), .TS_W(TW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spike_in     (spike_in),
    .spike_strobe (spike_strobe),
    .ev           (ev_if),
    .clear        (clear),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [TW-1:0] ts;
    logic          last;
  } ev_t;

  typedef struct {
    logic          s;
    logic [N-1:0]  sp;
    logic          r;
    logic          v;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
    logic          l;
    logic          b;
  } vec_t;

  // Model: every accepted frame is expanded into its events up front.
  ev_t        evq[$];
  ev_t        xlog[$];
  int         frames;
  logic [7:0] mts;
  logic       m_ov;
  logic [7:0] m_dc;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    xlog.delete();
    frames = 0;
    mts    = 8'd0;
    m_ov   = 1'b0;
    m_dc   = 8'd0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, ev_if.ev_valid, evq.size() > 0);
    if (evq.size() > 0) begin
      chk({tag, ".addr"}, ev_if.ev_addr, evq[0].addr);
      chk({tag, ".ts"},   ev_if.ev_ts,   evq[0].ts);
      chk({tag, ".last"}, ev_if.ev_last, evq[0].last);
    end
    chk({tag, ".busy"},     busy,     frames > 0);
    chk({tag, ".overflow"}, overflow, m_ov);
    chk({tag, ".drop_cnt"}, drop_cnt, m_dc);
  endtask

  task automatic model_step(input logic s, input logic [N-1:0] sp, input logic r, input logic c);
    logic xfer, pop, push, drop;
    int hi;
    xfer = (evq.size() > 0) && r;
    pop  = xfer && evq[0].last;
    push = 1'b0;
    drop = 1'b0;
    if (s && sp != '0) begin
      if (frames < DEPTH || pop) push = 1'b1;
      else                       drop = 1'b1;
    end
    if (c) begin
      m_ov = drop;
      m_dc = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      m_ov = 1'b1;
      if (m_dc != 8'd255) m_dc = m_dc + 8'd1;
    end
    if (xfer) begin
      xlog.push_back(evq[0]);
      if (evq[0].last) frames--;
      void'(evq.pop_front());
    end
    if (push) begin
      hi = 0;
      for (int i = 0; i < N; i++) if (sp[i]) hi = i;
      for (int i = 0; i < N; i++) begin
        if (sp[i]) evq.push_back('{addr: AW'(i), ts: mts, last: (i == hi)});
      end
      frames++;
    end
    if (s) mts = mts + 8'd1;
  endtask

  task automatic drive(input logic s, input logic [N-1:0] sp, input logic r, input logic c);
    spike_strobe   = s;
    spike_in       = sp;
    ev_if.ev_ready = r;
    clear          = c;
  endtask

  task automatic cycle(input logic s, input logic [N-1:0] sp, input logic r, input logic c);
    drive(s, sp, r, c);
    check_model("cyc");
    model_step(s, sp, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];

  initial begin
    ev_if.ev_ready = 1'b0;
    //          s  spike   r  v  a  t     l  b
    tbl[0]  = '{1, 8'hA4, 1, 0, 0, 8'd0, 0, 0};
    tbl[1]  = '{0, 8'h00, 1, 1, 2, 8'd0, 0, 1};
    tbl[2]  = '{0, 8'h00, 1, 1, 5, 8'd0, 0, 1};
    tbl[3]  = '{0, 8'h00, 1, 1, 7, 8'd0, 1, 1};
    tbl[4]  = '{1, 8'hA4, 0, 0, 0, 8'd0, 0, 0};
    tbl[5]  = '{0, 8'h00, 0, 1, 2, 8'd1, 0, 1};
    tbl[6]  = '{0, 8'h00, 0, 1, 2, 8'd1, 0, 1};
    tbl[7]  = '{0, 8'h00, 0, 1, 2, 8'd1, 0, 1};
    tbl[8]  = '{0, 8'h00, 1, 1, 2, 8'd1, 0, 1};
    tbl[9]  = '{0, 8'h00, 1, 1, 5, 8'd1, 0, 1};
    tbl[10] = '{0, 8'h00, 1, 1, 7, 8'd1, 1, 1};
    tbl[11] = '{0, 8'h00, 1, 0, 0, 8'd0, 0, 0};

    do_reset();
    chk("reset.valid", ev_if.ev_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.drop_cnt", drop_cnt, 0);

    // Single frame followed by the same frame under backpressure.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].s, tbl[i].sp, tbl[i].r, 1'b0);
      chk($sformatf("tbl%0d.valid", i), ev_if.ev_valid, tbl[i].v);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].b);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d.addr", i), ev_if.ev_addr, tbl[i].a);
        chk($sformatf("tbl%0d.ts", i), ev_if.ev_ts, tbl[i].t);
        chk($sformatf("tbl%0d.last", i), ev_if.ev_last, tbl[i].l);
      end
      model_step(tbl[i].s, tbl[i].sp, tbl[i].r, 1'b0);
      @(posedge clk);
      #1;
    end

    // Empty frames only advance the timestep.
    do_reset();
    repeat (3) cycle(1'b1, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h01, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty.count", xlog.size(), 1);
    if (xlog.size() == 1) begin
      chk("empty.addr", xlog[0].addr, 0);
      chk("empty.ts", xlog[0].ts, 3);
      chk("empty.last", xlog[0].last, 1);
    end

    // Overflow on the fifth frame, drain, then clear.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, N'(1) << k, 1'b0, 1'b0);
    chk("ovf.overflow", overflow, 1);
    chk("ovf.drop_cnt", drop_cnt, 1);
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf.count", xlog.size(), 4);
    for (int k = 0; k < 4 && k < xlog.size(); k++) begin
      chk($sformatf("ovf.addr%0d", k), xlog[k].addr, k);
      chk($sformatf("ovf.ts%0d", k), xlog[k].ts, k);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clear.overflow", overflow, 0);
    chk("clear.drop_cnt", drop_cnt, 0);

    // Timestep wrap, then back-to-back strobes streaming gap-free.
    do_reset();
    repeat (256) cycle(1'b1, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h80, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap.count", xlog.size(), 1);
    if (xlog.size() == 1) begin
      chk("wrap.addr", xlog[0].addr, 7);
      chk("wrap.ts", xlog[0].ts, 0);
    end
    xlog.delete();
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    cycle(1'b1, 8'h01, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("b2b.nogap", ev_if.ev_valid, 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("b2b.idle", ev_if.ev_valid, 0);
    chk("b2b.count", xlog.size(), 9);
    for (int k = 0; k < 9 && k < xlog.size(); k++) begin
      chk($sformatf("b2b.addr%0d", k), xlog[k].addr, (k < 8) ? k : 0);
      chk($sformatf("b2b.last%0d", k), xlog[k].last, (k >= 7));
      chk($sformatf("b2b.ts%0d", k), xlog[k].ts, (k < 8) ? 1 : 2);
    end

    // Asynchronous reset in the middle of a frame.
    do_reset();
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid.pre_valid", ev_if.ev_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.valid", ev_if.ev_valid, 0);
    chk("mid.addr", ev_if.ev_addr, 0);
    chk("mid.ts", ev_if.ev_ts, 0);
    chk("mid.last", ev_if.ev_last, 0);
    chk("mid.busy", busy, 0);
    chk("mid.overflow", overflow, 0);
    chk("mid.drop_cnt", drop_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h02, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid.count", xlog.size(), 1);
    if (xlog.size() == 1) begin
      chk("mid.after_addr", xlog[0].addr, 1);
      chk("mid.after_ts", xlog[0].ts, 0);
    end

    // Random traffic with alternating stall phases to exercise drops.
    do_reset();
    begin
      logic stall;
      logic s, r, c;
      logic [N-1:0] sp;
      stall = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if (n % 60 == 0) stall = ($urandom % 3 == 0);
        s  = ($urandom % 3 == 0);
        sp = ($urandom % 4 == 0) ? '0 : N'($urandom);
        r  = stall ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
        c  = ($urandom % 64 == 0);
        cycle(s, sp, r, c);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snn_aer_tx.md
# snn_aer_tx

Address-event (AER) transmitter for the LIF neuron core's output side. Once per network timestep it captures the core's output spike vector, queues each non-empty vector with its timestep stamp, and serialises it into one address-event per spiking neuron over a valid/ready stream. It sits between `tt_um_snn_core`'s spike outputs and any downstream consumer: a host link, a logger or a second core's input stage. It is the sending end of the spike-event interface that the core's input path receives.

## Interface

Parameters:
- `N_NEURONS`, 8: width of the spike vector.
- `ADDR_W`, 3: event address width; must satisfy 2^ADDR_W ≥ N_NEURONS.
- `TS_W`, 8: timestep counter width.
- `DEPTH`, 4: frame FIFO depth, in frames; a power of two ≥ 2.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `spike_in`  in  N_NEURONS: spike vector from the core; sampled only when `spike_strobe`=1.
- `spike_strobe`  in  1: end-of-timestep pulse, one cycle wide.
- `ev_valid`  out  1: an event is presented.
- `ev_ready`  in  1: the consumer accepts the event.
- `ev_addr`  out  ADDR_W: index of the spiking neuron.
- `ev_ts`  out  TS_W: timestep stamp of the event's frame.
- `ev_last`  out  1: final event of the current frame.
- `clear`  in  1: synchronous clear of the error status.
- `overflow`  out  1: sticky flag, set when any frame has been dropped.
- `drop_cnt`  out  8: dropped-frame count; saturates at 255.
- `busy`  out  1: the FIFO is non-empty.

## Operation

- Timestep counter `ts`:
  - Resets to 0.
  - Increments by 1 on every `spike_strobe`, wrapping modulo 2^TS_W.
  - A frame is tagged with `ts` as it was before the increment, so the first strobe after reset tags frame 0.
- Push rules:
  - On a strobe with `spike_in`≠0, push {`spike_in`, tag}.
  - A strobe with `spike_in`=0 pushes nothing; it only advances `ts`.
- Full FIFO:
  - A push succeeds when count<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the frame is dropped: `overflow`←1 and `drop_cnt` increments, saturating.
  - A drop never corrupts queued frames.
- Serialiser:
  - Holds a `sent` mask for the head frame.
  - `ev_addr` = lowest set bit of head_mask & ~sent.
  - `ev_last` = exactly one bit remains in head_mask & ~sent.
  - Events are emitted in ascending address order.
- Handshake:
  - A transfer occurs when `ev_valid`&`ev_ready`.
  - The transfer sets the bit in `sent`.
  - If the transfer has `ev_last`=1, the head frame is popped and `sent` is cleared in that same edge.
- Stream rules:
  - While `ev_valid`=1 and `ev_ready`=0, `ev_addr`, `ev_ts` and `ev_last` hold stable.
  - `ev_valid` never drops without a transfer, except on reset.
- State machine:
  - IDLE (FIFO empty, `ev_valid`=0) → SEND when the FIFO becomes non-empty.
  - SEND → IDLE on the final pop with no frame behind it.
  - SEND → SEND, reloading the next head, when more frames are queued.
- Status clear:
  - `clear` zeroes `overflow` and `drop_cnt`.
  - If a drop occurs in the same cycle as `clear`, the result is `overflow`=1 and `drop_cnt`=1.
- Reset (asserted at any time, including mid-frame) immediately sets:
  - the FIFO empty and `sent`=0;
  - `ts`=0;
  - `ev_valid`=0, `ev_addr`=0, `ev_ts`=0, `ev_last`=0;
  - `overflow`=0, `drop_cnt`=0, `busy`=0.
  - Any partially sent frame is discarded.

## Timing

- All outputs are registered, or decoded only from registered state; there is no combinational path from `ev_ready` or `spike_in` to any output.
- Latency: a strobe at edge t into an empty FIFO gives `ev_valid`=1 after edge t, i.e. first visible in cycle t+1.
- Throughput:
  - With `ev_ready` held at 1, one event per cycle.
  - Consecutive frames stream with no bubble: the first event of frame k+1 immediately follows the last event of frame k.
- `busy` and the push decision both reflect the count before the edge; a same-edge pop counts as freeing a slot.
- `spike_strobe` may occur on any cycle, including back-to-back cycles and the cycle of a pop.

## Test plan

- **Single frame.** Reset, then strobe with `spike_in`=8'b1010_0100, `ev_ready`=1.
  - Required: events (addr,ts,last) = (2,0,0), (5,0,0), (7,0,1) on cycles t+1 to t+3, then `ev_valid`=0 and `busy`=0.
- **Backpressure.** As in the single-frame case, with `ev_ready`=0 for 3 cycles.
  - Required: addr 2 held stable for those 3 cycles; after `ev_ready` rises, the same 3 events in the same order, none duplicated.
- **Empty frames.** Strobe 0x00 three times, then 0x01.
  - Required: exactly one event, addr 0 with ts 3 and last=1.
- **Overflow and clear.** `ev_ready`=0; strobe 0x01, 0x02, 0x04, 0x08, 0x10.
  - Required after the fifth strobe: `overflow`=1, `drop_cnt`=1.
  - Then `ev_ready`=1: addrs 0, 1, 2, 3 with ts 0 to 3 are emitted and the ts-4 frame never appears.
  - Then `clear`: both status outputs read 0.
- **Wrap and back-to-back.**
  - 256 strobes of 0x00, then 0x80: one event, ts 0, addr 7.
  - Strobes on consecutive cycles, 0xFF then 0x01, with `ev_ready`=1: 9 gap-free events, last=1 on addr 7 and on addr 0.
- **Reset mid-frame.** Assert `rst_n`=0 after the first event of frame 0xFF.
  - Required: all outputs go to zero asynchronously.
  - After release, a strobe of 0x02 yields only addr 1 with ts 0.
